spi_master_fsm: RTL and testbench

- SPI initiator for the lab's SPI memory slave. Generates sclk, cs and mosi, and samples miso.
- Frame is 16 bits, MSB first: 7-bit address, R/W bit (1 = read, 0 = write), then 8 data bits.
- Mode 0: sclk idles low, mosi changes while sclk is low, the slave samples on the sclk rising edge and updates miso on the falling edge.
- Sits between a host command interface and the FPGA pins, driving the slave from the same board.

---
 rtl/spi_master_fsm.sv | 145 ++++++++++++++
 tb/tb_spi_master_fsm.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_fsm.sv
// SPI mode-0 initiator for the lab SPI memory slave.
// Sends one 16-bit frame MSB first: {addr[6:0], rw, data[7:0]}. In read frames
// the slave returns a byte during the data phase, which is captured into rdata.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start, rw, addr,    transfer request; rw/addr/wdata latched when start is
//   wdata               accepted in IDLE
//   miso                serial data from the slave
//   sclk, cs, mosi      SPI pins (sclk idles 0, cs active low)
//   busy, done          busy from accept through DONE; done is a 1-cycle pulse
//   rdata               last byte read, held until the next read completes
module spi_master_fsm #(
  parameter int unsigned CLKDIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       miso,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata
);

  localparam int unsigned HW = $clog2(CLKDIV);
  localparam logic [HW-1:0] HLAST = HW'(CLKDIV - 1);

  typedef enum logic [2:0] {IDLE, LEAD, SCLK_HI, SCLK_LO, DONE} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [15:0]   shift_q, shift_d;
  logic          rw_q, rw_d;
  logic [7:0]    shadow_q, shadow_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          sclk_q, cs_q, mosi_q, busy_q, done_q;
  logic          phase_end;
  logic          active_d;

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    shadow_d  = shadow_q;
    rdata_d   = rdata_q;
    phase_end = (hcnt_q == HLAST);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LEAD;
          // Read frames carry zeros in the data phase, so the data byte is
          // masked at load time rather than gated on the pin.
          shift_d  = {addr, rw, (rw ? 8'h00 : wdata)};
          rw_d     = rw;
          bitcnt_d = '0;
          hcnt_d   = '0;
        end
      end
      LEAD: begin
        hcnt_d = hcnt_q + HW'(1);
        if (phase_end) begin
          state_d = SCLK_HI;
          hcnt_d  = '0;
        end
      end
      SCLK_HI: begin
        hcnt_d = hcnt_q + HW'(1);
        if (phase_end) begin
          // Sample late in the high phase; the slave changed miso on the
          // previous falling edge.
          if (bitcnt_q[3] && rw_q) shadow_d = {shadow_q[6:0], miso};
          if (bitcnt_q != 4'd15) shift_d = {shift_q[14:0], 1'b0};
          state_d = SCLK_LO;
          hcnt_d  = '0;
        end
      end
      SCLK_LO: begin
        hcnt_d = hcnt_q + HW'(1);
        if (phase_end) begin
          hcnt_d = '0;
          if (bitcnt_q == 4'd15) begin
            state_d = DONE;
            // Loaded on entry to DONE so rdata is valid alongside done.
            if (rw_q) rdata_d = shadow_q;
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
            state_d  = SCLK_HI;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    active_d = (state_d == LEAD) || (state_d == SCLK_HI) || (state_d == SCLK_LO);
  end

  // Pin outputs are computed from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      rw_q     <= 1'b0;
      shadow_q <= '0;
      rdata_q  <= '0;
      sclk_q   <= 1'b0;
      cs_q     <= 1'b1;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      rw_q     <= rw_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      sclk_q   <= (state_d == SCLK_HI);
      cs_q     <= !active_d;
      mosi_q   <= active_d && shift_d[15];
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
    end
  end

  assign sclk  = sclk_q;
  assign cs    = cs_q;
  assign mosi  = mosi_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_spi_master_fsm.sv
module tb_spi_master_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // CLKDIV=4 instance
  logic       rst4, start4, rw4;
  logic       miso4 = 1'b0;
  logic [6:0] addr4;
  logic [7:0] wdata4;
  logic       sclk4, cs4, mosi4, busy4, done4;
  logic [7:0] rdata4;

  // CLKDIV=2 instance
  logic       rst2, start2, rw2;
  logic       miso2 = 1'b0;
  logic [6:0] addr2;
  logic [7:0] wdata2;
  logic       sclk2, cs2, mosi2, busy2, done2;
  logic [7:0] rdata2;

  spi_master_fsm #(.CLKDIV(4)) dut4 (
    .clk(clk), .reset(rst4), .start(start4), .rw(rw4), .addr(addr4),
    .wdata(wdata4), .miso(miso4), .sclk(sclk4), .cs(cs4), .mosi(mosi4),
    .busy(busy4), .done(done4), .rdata(rdata4)
  );

  spi_master_fsm #(.CLKDIV(2)) dut2 (
    .clk(clk), .reset(rst2), .start(start2), .rw(rw2), .addr(addr2),
    .wdata(wdata2), .miso(miso2), .sclk(sclk2), .cs(cs2), .mosi(mosi2),
    .busy(busy2), .done(done2), .rdata(rdata2)
  );

  // Slave models: capture mosi on sclk rising edges, present the read byte
  // MSB first starting after the 8th falling edge of the frame.
  logic [7:0]  rb4 = 8'h00, rb2 = 8'h00;
  logic [15:0] frm4 = '0, frm2 = '0;
  int          nre4 = 0, nfe4 = 0, nre2 = 0, nfe2 = 0;
  logic        pcs4 = 1'b1, psclk4 = 1'b0, pcs2 = 1'b1, psclk2 = 1'b0;

  always @(negedge clk) begin
    if (pcs4 && !cs4) begin frm4 = '0; nre4 = 0; nfe4 = 0; miso4 = 1'b0; end
    if (!cs4 && sclk4 && !psclk4) begin frm4 = {frm4[14:0], mosi4}; nre4++; end
    if (!cs4 && !sclk4 && psclk4) begin
      nfe4++;
      miso4 = (nfe4 >= 8 && nfe4 < 16) ? rb4[15-nfe4] : 1'b0;
    end
    pcs4 = cs4; psclk4 = sclk4;
  end

  always @(negedge clk) begin
    if (pcs2 && !cs2) begin frm2 = '0; nre2 = 0; nfe2 = 0; miso2 = 1'b0; end
    if (!cs2 && sclk2 && !psclk2) begin frm2 = {frm2[14:0], mosi2}; nre2++; end
    if (!cs2 && !sclk2 && psclk2) begin
      nfe2++;
      miso2 = (nfe2 >= 8 && nfe2 < 16) ? rb2[15-nfe2] : 1'b0;
    end
    pcs2 = cs2; psclk2 = sclk2;
  end

  // Reference model: frame contents and the rdata the host should see.
  logic [7:0] model_rd4 = 8'h00;

  function automatic logic [15:0] model_frame(input logic [6:0] a, input logic r,
                                              input logic [7:0] wd);
    return {a, r, (r ? 8'h00 : wd)};
  endfunction

  // Observations from one CLKDIV=4 transfer (cycle 1 = first cycle after accept).
  int         o_first, o_last, o_nlow, o_ndone, o_done, o_busy0;
  logic [7:0] o_rd_done;

  task automatic xfer4(input logic [6:0] a, input logic r, input logic [7:0] wd,
                       input logic [7:0] rb, input bit poke);
    @(negedge clk);
    rb4 = rb; addr4 = a; rw4 = r; wdata4 = wd; start4 = 1'b1;
    o_first = -1; o_last = -1; o_nlow = 0; o_ndone = 0; o_done = -1; o_busy0 = -1;
    o_rd_done = 8'hxx;
    for (int cyc = 1; cyc <= 150; cyc++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (cs4 === 1'b0) begin
        o_nlow++;
        if (o_first < 0) o_first = cyc;
        o_last = cyc;
      end
      if (done4 === 1'b1) begin o_ndone++; o_done = cyc; o_rd_done = rdata4; end
      if (busy4 === 1'b0 && o_busy0 < 0) o_busy0 = cyc;
      start4 = poke && (cyc == 40 || done4 === 1'b1);
    end
    if (r) model_rd4 = rb;
  endtask

  task automatic test_reset();
    rst4 = 1'b1; rst2 = 1'b1;
    repeat (3) @(negedge clk);
    rst4 = 1'b0; rst2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if ({cs4, sclk4, mosi4, busy4, done4, rdata4} !== {1'b1, 4'b0000, 8'h00}) begin
        fails++;
        $display("FAIL reset_idle4 cyc=%0d got cs=%b sclk=%b mosi=%b busy=%b done=%b rdata=%h want 1 0 0 0 0 00",
                 i, cs4, sclk4, mosi4, busy4, done4, rdata4);
      end
      tests++;
      if ({cs2, sclk2, mosi2, busy2, done2, rdata2} !== {1'b1, 4'b0000, 8'h00}) begin
        fails++;
        $display("FAIL reset_idle2 cyc=%0d got cs=%b sclk=%b mosi=%b busy=%b done=%b rdata=%h want 1 0 0 0 0 00",
                 i, cs2, sclk2, mosi2, busy2, done2, rdata2);
      end
    end
  endtask

  task automatic test_write();
    logic [15:0] ef;
    ef = model_frame(7'h2A, 1'b0, 8'hC3);
    xfer4(7'h2A, 1'b0, 8'hC3, 8'($urandom), 1'b0);
    tests++;
    if (frm4 !== ef || nre4 != 16) begin
      fails++; $display("FAIL write_frame got %b (%0d edges) want %b (16 edges)", frm4, nre4, ef);
    end
    tests++;
    if (o_first != 1 || o_last != 132 || o_nlow != 132) begin
      fails++; $display("FAIL write_cs got low %0d..%0d n=%0d want 1..132 n=132", o_first, o_last, o_nlow);
    end
    tests++;
    if (o_ndone != 1 || o_done != 133) begin
      fails++; $display("FAIL write_done got n=%0d at %0d want n=1 at 133", o_ndone, o_done);
    end
    tests++;
    if (rdata4 !== model_rd4) begin
      fails++; $display("FAIL write_rdata got %h want %h", rdata4, model_rd4);
    end
  endtask

  task automatic test_read();
    logic [15:0] ef;
    ef = model_frame(7'h55, 1'b1, 8'h00);
    xfer4(7'h55, 1'b1, 8'($urandom), 8'hA5, 1'b0);
    tests++;
    if (frm4 !== ef) begin
      fails++; $display("FAIL read_frame got %b want %b", frm4, ef);
    end
    tests++;
    if (o_rd_done !== 8'hA5 || o_done != 133) begin
      fails++; $display("FAIL read_rdata_at_done got %h at %0d want a5 at 133", o_rd_done, o_done);
    end
    tests++;
    if (rdata4 !== model_rd4) begin
      fails++; $display("FAIL read_rdata_held got %h want %h", rdata4, model_rd4);
    end
  endtask

  task automatic test_ignore_start();
    logic [6:0] a;
    logic       r;
    a = 7'($urandom); r = 1'($urandom_range(0, 1));
    xfer4(a, r, 8'($urandom), 8'($urandom), 1'b1);
    tests++;
    if (o_ndone != 1 || o_nlow != 132 || o_last != 132) begin
      fails++; $display("FAIL ignore_start_frames got done=%0d cslow=%0d last=%0d want 1 132 132",
                        o_ndone, o_nlow, o_last);
    end
    tests++;
    if (o_busy0 != 134) begin
      fails++; $display("FAIL ignore_start_busy got busy low at %0d want 134", o_busy0);
    end
    tests++;
    if (rdata4 !== model_rd4) begin
      fails++; $display("FAIL ignore_start_rdata got %h want %h", rdata4, model_rd4);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  rb;
    logic [15:0] ef;
    int          nd;
    @(negedge clk);
    rb4 = 8'($urandom); addr4 = 7'($urandom); rw4 = 1'b1; start4 = 1'b1;
    for (int cyc = 1; cyc <= 46; cyc++) begin
      @(negedge clk);
      start4 = 1'b0;
    end
    // cycle 46 lies inside the high phase of bit 5 (cycles 45..48)
    tests++;
    if (sclk4 !== 1'b1 || nre4 != 6) begin
      fails++; $display("FAIL reset_mid_position got sclk=%b edges=%0d want 1 6", sclk4, nre4);
    end
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    model_rd4 = 8'h00;
    tests++;
    if ({cs4, sclk4, mosi4, busy4, done4, rdata4} !== {1'b1, 4'b0000, 8'h00}) begin
      fails++;
      $display("FAIL reset_mid_outputs got cs=%b sclk=%b mosi=%b busy=%b done=%b rdata=%h want 1 0 0 0 0 00",
               cs4, sclk4, mosi4, busy4, done4, rdata4);
    end
    nd = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (done4 === 1'b1 || cs4 !== 1'b1) nd++;
    end
    tests++;
    if (nd != 0) begin
      fails++; $display("FAIL reset_mid_no_done got %0d active cycles want 0", nd);
    end
    rb = 8'($urandom);
    ef = model_frame(7'h3C, 1'b1, 8'h00);
    xfer4(7'h3C, 1'b1, 8'($urandom), rb, 1'b0);
    tests++;
    if (o_rd_done !== rb || rdata4 !== rb || frm4 !== ef) begin
      fails++; $display("FAIL reset_mid_followup got rdata=%h/%h frame=%b want %h frame=%b",
                        o_rd_done, rdata4, frm4, rb, ef);
    end
  endtask

  task automatic test_random();
    logic [6:0]  a;
    logic        r;
    logic [7:0]  wd, rb;
    logic [15:0] ef;
    for (int n = 0; n < 6; n++) begin
      a = 7'($urandom); r = 1'($urandom_range(0, 1)); wd = 8'($urandom); rb = 8'($urandom);
      ef = model_frame(a, r, wd);
      xfer4(a, r, wd, rb, 1'b0);
      tests++;
      if (frm4 !== ef || nre4 != 16) begin
        fails++; $display("FAIL random_frame n=%0d got %b (%0d edges) want %b", n, frm4, nre4, ef);
      end
      tests++;
      if (o_nlow != 132 || o_done != 133 || o_ndone != 1) begin
        fails++; $display("FAIL random_timing n=%0d got cslow=%0d done=%0d x%0d want 132 133 x1",
                          n, o_nlow, o_done, o_ndone);
      end
      tests++;
      if (rdata4 !== model_rd4) begin
        fails++; $display("FAIL random_rdata n=%0d got %h want %h", n, rdata4, model_rd4);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rbq [3];
    int         low, high, nd;
    low = 0; high = 0; nd = 0;
    for (int i = 0; i < 3; i++) rbq[i] = 8'($urandom);
    @(negedge clk);
    addr2 = 7'($urandom); rw2 = 1'b1; wdata2 = 8'($urandom); rb2 = rbq[0]; start2 = 1'b1;
    for (int cyc = 1; cyc <= 300 && nd < 3; cyc++) begin
      @(negedge clk);
      if (cs2 === 1'b0) begin
        if (high > 0) begin
          tests++;
          if (high != 2) begin
            fails++; $display("FAIL b2b_gap got cs high %0d cycles want 2", high);
          end
        end
        high = 0;
        low++;
      end else begin
        if (low > 0) begin
          tests++;
          if (low != 66) begin
            fails++; $display("FAIL b2b_cs_low got %0d cycles want 66", low);
          end
          low = 0;
        end
        high++;
      end
      if (done2 === 1'b1) begin
        tests++;
        if (rdata2 !== rbq[nd]) begin
          fails++; $display("FAIL b2b_rdata frame=%0d got %h want %h", nd, rdata2, rbq[nd]);
        end
        tests++;
        if (frm2 !== model_frame(addr2, 1'b1, 8'h00)) begin
          fails++; $display("FAIL b2b_frame frame=%0d got %b want %b", nd, frm2,
                            model_frame(addr2, 1'b1, 8'h00));
        end
        nd++;
        if (nd < 3) rb2 = rbq[nd];
        else start2 = 1'b0;
      end
    end
    start2 = 1'b0;
    tests++;
    if (nd != 3) begin
      fails++; $display("FAIL b2b_count got %0d done pulses want 3", nd);
    end
  endtask

  initial begin
    rst4 = 1'b1; rst2 = 1'b1;
    start4 = 1'b0; start2 = 1'b0;
    rw4 = 1'b0; rw2 = 1'b0;
    addr4 = '0; addr2 = '0;
    wdata4 = '0; wdata2 = '0;
    test_reset();
    test_write();
    test_read();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
